present_inv_sbox_layer: RTL and testbench

Iterative inverse substitution layer for the PRESENT decryption datapath. It accepts a 64-bit cipher state over a valid/ready handshake and applies the inverse 4-bit S-box to all 16 nibbles, LANES nibbles per cycle. It returns the result over a second valid/ready handshake. It sits between the round-key XOR and the next decryption round, and optionally applies the inverse pLayer first.

---
 rtl/present_pkg.sv | 25 ++
 rtl/present_inv_sbox.sv | 11 +
 rtl/present_inv_sbox_layer.sv | 133 +++++++++++++
 tb/tb_present_inv_sbox_layer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, inverse S-box table, FSM states and inverse pLayer index.
package present_pkg;

  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;

  // Nibble k of this constant is the inverse S-box output for input k.
  localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PERM = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } fsm_state_e;

  // Destination bit of source bit j under the inverse pLayer.
  function automatic logic [5:0] inv_player_idx(input logic [5:0] j);
    if (j == 6'd63) begin
      return 6'd63;
    end
    return 6'((4 * int'(j)) % 63);
  endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// rtl/present_inv_sbox.sv - 4-bit combinational PRESENT inverse S-box lookup.
module present_inv_sbox
  import present_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = INV_SBOX_TABLE[{nib_i, 2'b00} +: 4];

endmodule

// File: rtl/present_inv_sbox_layer.sv
// rtl/present_inv_sbox_layer.sv - iterative PRESENT inverse S-box layer, LANES nibbles per cycle.
// Optional inverse pLayer stage ahead of substitution: PRESENT_INV_PLAYER_EN.
module present_inv_sbox_layer
  import present_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out,
  output logic               busy
);

  localparam int N     = NIBBLES / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("present_inv_sbox_layer: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_state_e         fsm_q, fsm_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [STATE_W-1:0] data_out_q, data_out_d;

  logic [3:0] lane_idx [LANES];
  logic [3:0] lane_in  [LANES];
  logic [3:0] lane_out [LANES];

  // Lane l of this cycle works on nibble cnt*LANES + l.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
      lane_in[l]  = st_q[{lane_idx[l], 2'b00} +: 4];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    present_inv_sbox u_sbox (
      .nib_i(lane_in[g]),
      .nib_o(lane_out[g])
    );
  end

`ifdef PRESENT_INV_PLAYER_EN
  logic [STATE_W-1:0] st_perm;

  always_comb begin
    st_perm = '0;
    for (int j = 0; j < STATE_W; j++) begin
      st_perm[inv_player_idx(6'(j))] = st_q[j];
    end
  end
`endif

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = data_in;
          cnt_d = '0;
`ifdef PRESENT_INV_PLAYER_EN
          fsm_d = PERM;
`else
          fsm_d = SUB;
`endif
        end
      end
`ifdef PRESENT_INV_PLAYER_EN
      PERM: begin
        st_d  = st_perm;
        fsm_d = SUB;
      end
`endif
      SUB: begin
        for (int l = 0; l < LANES; l++) begin
          st_d[{lane_idx[l], 2'b00} +: 4] = lane_out[l];
        end
        if (cnt_q == CNT_LAST) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

    // Outputs are registered from the next state so nothing partial leaks out.
    out_valid_d = (fsm_d == DONE);
    data_out_d  = (fsm_d == DONE) ? st_d : '0;
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      data_out_q  <= data_out_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_present_inv_sbox_layer.sv
// tb/tb_present_inv_sbox_layer.sv - self-checking bench for present_inv_sbox_layer.
module tb_present_inv_sbox_layer;

  localparam int LANES = 4;
  localparam int N     = 16 / LANES;
`ifdef PRESENT_INV_PLAYER_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = N + EXTRA;

  localparam int SB_REF [16] = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic        busy;

  logic        xv;
  logic        x_ready;
  logic        x_in_ready  [4];
  logic        x_out_valid [4];
  logic [63:0] x_data_out  [4];
  logic        x_busy      [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  present_inv_sbox_layer #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_x
    present_inv_sbox_layer #(.LANES(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16)) u_x (
      .clk(clk), .rst(rst), .in_valid(xv), .in_ready(x_in_ready[g]), .data_in(data_in),
      .out_valid(x_out_valid[g]), .out_ready(x_ready), .data_out(x_data_out[g]), .busy(x_busy[g])
    );
  end

  function automatic logic [63:0] ref_layer(input logic [63:0] s);
    logic [63:0] p;
    logic [63:0] r;
    p = s;
`ifdef PRESENT_INV_PLAYER_EN
    p = '0;
    for (int j = 0; j < 64; j++) begin
      int dst;
      dst = (j == 63) ? 63 : (4 * j) % 63;
      p[dst] = s[j];
    end
`endif
    for (int k = 0; k < 16; k++) begin
      r[4*k +: 4] = 4'(SB_REF[p[4*k +: 4]]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_wait", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic run_one(input logic [63:0] din, output logic [63:0] dout, output int lat);
    wait_ready();
    in_valid = 1'b1;
    data_in  = din;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    dout = data_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [63:0] res, res2, held, a, b;
    int          lat;
    int          xlat [4];
    logic [63:0] xres [4];

`ifdef PRESENT_INV_PLAYER_EN
    v.din = 64'h0;                v.exp = 64'h5555555555555555; vecs.push_back(v);
    v.din = 64'h0000000000000002; v.exp = 64'h55555555555555E5; vecs.push_back(v);
    v.din = 64'h8000000000000000; v.exp = 64'hB555555555555555; vecs.push_back(v);
`else
    v.din = 64'h0;                v.exp = 64'h5555555555555555; vecs.push_back(v);
    v.din = 64'hC56B90AD3EF84712; v.exp = 64'h0123456789ABCDEF; vecs.push_back(v);
    v.din = 64'hFFFFFFFFFFFFFFFF; v.exp = 64'hAAAAAAAAAAAAAAAA; vecs.push_back(v);
`endif
    for (int i = 0; i < 12; i++) begin
      v.din = {$urandom, $urandom};
      v.exp = ref_layer(v.din);
      vecs.push_back(v);
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; xv = 1'b0; x_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_one(vecs[i].din, res, lat);
      chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
    end

    // Backpressure with a competing input held during DONE.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    wait_ready();
    in_valid = 1'b1; data_in = a;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid();
    held = data_out;
    chk("bp_data", held, ref_layer(a));
    in_valid = 1'b1; data_in = b;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_data_stable", data_out, held);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_busy", {63'd0, busy}, 64'd0);

    // Reset while in SUB with cnt=2.
    wait_ready();
    in_valid = 1'b1; data_in = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2 + EXTRA) @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data_out", data_out, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", {63'd0, in_ready}, 64'd1);
    run_one(64'h0, res, lat);
    chk("after_rst_data", res, 64'h5555555555555555);
    chk("after_rst_latency", 64'(lat), 64'(LAT));

    // Back-to-back with out_ready tied high.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    out_ready = 1'b1;
    wait_ready();
    in_valid = 1'b1; data_in = a;
    @(negedge clk);
    data_in = b;
    wait_out_valid();
    res = data_out;
    @(negedge clk);
    chk("b2b_gap_valid", {63'd0, out_valid}, 64'd0);
    chk("b2b_gap_in_ready", {63'd0, in_ready}, 64'd1);
    chk("b2b_gap_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_busy", {63'd0, busy}, 64'd1);
    chk("b2b_second_in_ready", {63'd0, in_ready}, 64'd0);
    wait_out_valid();
    res2 = data_out;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_first_data", res, ref_layer(a));
    chk("b2b_second_data", res2, ref_layer(b));

    // Latency and result for the other lane counts.
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("x%0d_idle_ready", g), {63'd0, x_in_ready[g]}, 64'd1);
      xlat[g] = 0;
      xres[g] = '0;
    end
    data_in = 64'hC56B90AD3EF84712;
    xv = 1'b1;
    @(negedge clk);
    xv = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (x_out_valid[g] && xlat[g] == 0) begin
          xlat[g] = cyc;
          xres[g] = x_data_out[g];
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      int lanes_g;
      lanes_g = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      chk($sformatf("lanes%0d_latency", lanes_g), 64'(xlat[g]), 64'(16 / lanes_g + EXTRA));
      chk($sformatf("lanes%0d_data", lanes_g), xres[g], ref_layer(64'hC56B90AD3EF84712));
      chk($sformatf("lanes%0d_idle", lanes_g), {63'd0, x_busy[g]}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
